// File: rtl/calc_traffic_engine.sv
// calc_traffic_engine: multi-port tagged request generator and response checker for calc2 DUTs
module calc_traffic_engine #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic                           c_clk,
    input  logic                           reset,
    input  logic                           ld_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]   ld_port,
    input  logic [3:0]                     ld_cmd,
    input  logic [DATA_W-1:0]              ld_op1,
    input  logic [DATA_W-1:0]              ld_op2,
    output logic                           ld_ready,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_PORTS*4-1:0]         req_cmd,
    output logic [NUM_PORTS*DATA_W-1:0]    req_data,
    output logic [NUM_PORTS*TAG_W-1:0]     req_tag,
    input  logic [NUM_PORTS*2-1:0]         out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0]    out_data,
    input  logic [NUM_PORTS*TAG_W-1:0]     out_tag,
    output logic [CNT_W-1:0]               pass_cnt,
    output logic [CNT_W-1:0]               fail_cnt,
    output logic [CNT_W-1:0]               timeout_cnt,
    output logic                           err_valid,
    output logic [$clog2(NUM_PORTS)-1:0]   err_port,
    output logic [TAG_W-1:0]               err_tag
);
    localparam int PW  = $clog2(NUM_PORTS);
    localparam int NT  = 1 << TAG_W;
    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam int AW  = $clog2(TIMEOUT + 1);
    localparam int SW  = $clog2(DATA_W);
    localparam int IW  = $clog2(NUM_PORTS * NT + 1);
    localparam int CW1 = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

    logic [NUM_PORTS-1:0]    empty, full, idle, any_valid, pass_p, fail_p;
    logic [NUM_PORTS*NT-1:0] to_vec;
    logic                    start_ok, all_clear;
    logic [IW-1:0]           pass_inc, fail_inc, to_inc;
    logic [PW-1:0]           f_port, t_port;
    logic [TAG_W-1:0]        f_tag, t_tag;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input logic [IW-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + CW1'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign ld_ready  = !busy && !full[ld_port];
    assign start_ok  = start && !busy && !(&empty);
    assign all_clear = (&idle) && (&empty) && !(|any_valid);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_t              state, state_nx;
        logic [3:0]          f_cmd [FIFO_DEPTH];
        logic [DATA_W-1:0]   f_op1 [FIFO_DEPTH];
        logic [DATA_W-1:0]   f_op2 [FIFO_DEPTH];
        logic [FW:0]         wr_ptr, rd_ptr;
        logic [TAG_W-1:0]    next_tag;
        logic [NT-1:0]       valid, expire;
        logic [1:0]          e_resp [NT];
        logic [DATA_W-1:0]   e_data [NT];
        logic [AW-1:0]       age [NT];
        logic [3:0]          h_cmd;
        logic [DATA_W-1:0]   h_op1, h_op2, rf_data, o_data;
        logic [DATA_W:0]     sum;
        logic [1:0]          rf_resp, o_resp;
        logic [TAG_W-1:0]    o_tag;
        logic                ld_fire, hit, ok;

        assign o_resp   = out_resp[p*2 +: 2];
        assign o_data   = out_data[p*DATA_W +: DATA_W];
        assign o_tag    = out_tag[p*TAG_W +: TAG_W];
        assign ld_fire  = ld_valid && ld_ready && ld_port == PW'(p);
        assign empty[p] = wr_ptr == rd_ptr;
        assign full[p]  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
        assign h_cmd    = f_cmd[rd_ptr[FW-1:0]];
        assign h_op1    = f_op1[rd_ptr[FW-1:0]];
        assign h_op2    = f_op2[rd_ptr[FW-1:0]];
        assign sum      = {1'b0, h_op1} + {1'b0, h_op2};
        // Reference result for the request at the FIFO head; an invalid command expects an error response.
        assign rf_resp  = (h_cmd == 4'd1) ? (sum[DATA_W] ? 2'd2 : 2'd1) :
                          (h_cmd == 4'd2) ? ((h_op2 > h_op1) ? 2'd2 : 2'd1) :
                          (h_cmd == 4'd5 || h_cmd == 4'd6) ? 2'd1 : 2'd2;
        assign rf_data  = (h_cmd == 4'd1) ? sum[DATA_W-1:0] :
                          (h_cmd == 4'd2) ? h_op1 - h_op2 :
                          (h_cmd == 4'd5) ? h_op1 << h_op2[SW-1:0] :
                          (h_cmd == 4'd6) ? h_op1 >> h_op2[SW-1:0] : '0;
        assign hit          = o_resp != 2'd0;
        assign ok           = valid[o_tag] && o_resp == e_resp[o_tag] &&
                              (o_resp == 2'd2 || o_data == e_data[o_tag]);
        assign pass_p[p]    = hit && ok;
        assign fail_p[p]    = hit && !ok;
        assign idle[p]      = state == IDLE;
        assign any_valid[p] = |valid;
        assign to_vec[p*NT +: NT] = expire;
        assign req_cmd[p*4 +: 4]           = (state == ISSUE1) ? h_cmd : 4'd0;
        assign req_data[p*DATA_W +: DATA_W] = (state == ISSUE1) ? h_op1 : (state == ISSUE2) ? h_op2 : '0;
        assign req_tag[p*TAG_W +: TAG_W]    = (state == ISSUE1) ? next_tag : '0;

        // Entries reaching the age limit expire unless a response for that tag lands this cycle.
        always_comb begin
            expire = '0;
            for (int t = 0; t < NT; t++)
                expire[t] = valid[t] && age[t] == AW'(TIMEOUT) && !(hit && o_tag == TAG_W'(t));
        end

        // Issue sequencing: a request starts only when its tag slot is free.
        always_comb begin
            state_nx = (state == IDLE)   ? ((busy && !empty[p] && !valid[next_tag]) ? ISSUE1 : IDLE) :
                       (state == ISSUE1) ? ISSUE2 : IDLE;
        end

        // Per-port issue state register.
        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) state <= IDLE;
            else       state <= state_nx;
        end

        // Request FIFO storage; contents are don't-care while the pointers say empty.
        always_ff @(posedge c_clk) begin
            if (ld_fire) begin
                f_cmd[wr_ptr[FW-1:0]] <= ld_cmd;
                f_op1[wr_ptr[FW-1:0]] <= ld_op1;
                f_op2[wr_ptr[FW-1:0]] <= ld_op2;
            end
        end

        // FIFO pointers and tag allocator; the pop and tag advance happen in the second issue cycle.
        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                next_tag <= '0;
            end else begin
                if (ld_fire) wr_ptr <= wr_ptr + 1'b1;
                if (state == ISSUE2) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    next_tag <= next_tag + 1'b1;
                end
            end
        end

        // Outstanding-tag table: allocate on issue, retire on response or on age limit.
        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                valid <= '0;
                for (int t = 0; t < NT; t++) begin
                    e_resp[t] <= '0;
                    e_data[t] <= '0;
                    age[t]    <= '0;
                end
            end else begin
                for (int t = 0; t < NT; t++) begin
                    if (valid[t]) age[t] <= age[t] + AW'(1);
                    if (valid[t] && ((hit && o_tag == TAG_W'(t)) || age[t] == AW'(TIMEOUT))) valid[t] <= 1'b0;
                    if (state == ISSUE1 && next_tag == TAG_W'(t)) begin
                        valid[t]  <= 1'b1;
                        e_resp[t] <= rf_resp;
                        e_data[t] <= rf_data;
                        age[t]    <= '0;
                    end
                end
            end
        end
    end

    // Per-cycle event counts and lowest-numbered error source; descending scan lets the lowest index win.
    always_comb begin
        pass_inc = '0;
        fail_inc = '0;
        to_inc   = '0;
        f_port   = '0;
        f_tag    = '0;
        t_port   = '0;
        t_tag    = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            pass_inc = pass_inc + IW'(pass_p[p]);
            fail_inc = fail_inc + IW'(fail_p[p]);
            if (fail_p[p]) begin
                f_port = PW'(p);
                f_tag  = out_tag[p*TAG_W +: TAG_W];
            end
            for (int t = NT - 1; t >= 0; t--) begin
                if (to_vec[p*NT + t]) begin
                    to_inc = to_inc + IW'(1);
                    t_port = PW'(p);
                    t_tag  = TAG_W'(t);
                end
            end
        end
    end

    // Run control: busy from an accepted start until everything drains, then a single done pulse.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= busy && all_clear;
            if (start_ok)               busy <= 1'b1;
            else if (busy && all_clear) busy <= 1'b0;
        end
    end

    // Saturating statistics, cleared by an accepted start; failures outrank timeouts in the error report.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_cnt <= '0;
            err_valid   <= 1'b0;
            err_port    <= '0;
            err_tag     <= '0;
        end else begin
            pass_cnt    <= start_ok ? '0 : sat(pass_cnt, pass_inc);
            fail_cnt    <= start_ok ? '0 : sat(fail_cnt, fail_inc);
            timeout_cnt <= start_ok ? '0 : sat(timeout_cnt, to_inc);
            err_valid   <= (|fail_p) || (|to_vec);
            if (|fail_p) begin
                err_port <= f_port;
                err_tag  <= f_tag;
            end else if (|to_vec) begin
                err_port <= t_port;
                err_tag  <= t_tag;
            end
        end
    end
endmodule

// File: tb/tb_calc_traffic_engine.sv
// tb_calc_traffic_engine: directed checks of issue protocol, tag matching, timeouts and reset
module tb_calc_traffic_engine;
    logic         c_clk = 1'b0;
    logic         reset, ld_valid, start;
    logic [1:0]   ld_port;
    logic [3:0]   ld_cmd;
    logic [31:0]  ld_op1, ld_op2;
    logic         ld_ready, busy, done, err_valid;
    logic [15:0]  req_cmd;
    logic [127:0] req_data, out_data;
    logic [7:0]   req_tag, out_resp, out_tag;
    logic [15:0]  pass_cnt, fail_cnt, timeout_cnt;
    logic [1:0]   err_port, err_tag;
    int           vectors = 0;
    int           miscompares = 0;
    int           ntag [4] = '{0, 0, 0, 0};
    int           cnt;

    calc_traffic_engine dut (
        .c_clk(c_clk), .reset(reset), .ld_valid(ld_valid), .ld_port(ld_port), .ld_cmd(ld_cmd),
        .ld_op1(ld_op1), .ld_op2(ld_op2), .ld_ready(ld_ready), .start(start), .busy(busy),
        .done(done), .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt), .err_valid(err_valid),
        .err_port(err_port), .err_tag(err_tag)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge c_clk);
    endtask

    task automatic load(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ld_valid = 1'b1; ld_port = 2'(p); ld_cmd = c; ld_op1 = a; ld_op2 = b;
        cyc(1);
        ld_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic set_reply(input int p, input logic [1:0] r, input logic [31:0] d, input int t);
        out_resp[p*2 +: 2] = r;
        out_data[p*32 +: 32] = d;
        out_tag[p*2 +: 2] = 2'(t);
    endtask

    task automatic fire();
        cyc(1);
        out_resp = '0; out_data = '0; out_tag = '0;
    endtask

    task automatic wait_issue(input int p, input int bound);
        int n = 0;
        while (req_cmd[p*4 +: 4] == 4'd0 && n < bound) begin cyc(1); n++; end
        chk("issue_seen", 64'(n < bound), 1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin cyc(1); n++; end
        chk("done_seen", 64'(n < bound), 1);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 0; start = 0; ld_port = 0; ld_cmd = 0; ld_op1 = 0; ld_op2 = 0;
        out_resp = '0; out_data = '0; out_tag = '0;
        cyc(2);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnts", {pass_cnt, fail_cnt, timeout_cnt}, 0);
        chk("rst_req", 64'(req_cmd == 0 && req_data == 0 && req_tag == 0), 1);
        chk("rst_err", {err_valid, err_port, err_tag}, 0);
        chk("rst_ld_ready", ld_ready, 1);
        go();
        chk("empty_start_busy", busy, 0);

        load(0, 4'd2, 32'h158, 32'h12);
        go();
        chk("s1_busy", busy, 1);
        wait_issue(0, 10);
        chk("s1_i1_cmd", req_cmd[3:0], 2);
        chk("s1_i1_data", req_data[31:0], 32'h158);
        chk("s1_i1_tag", req_tag[1:0], 0);
        cyc(1);
        chk("s1_i2_cmd", req_cmd[3:0], 0);
        chk("s1_i2_data", req_data[31:0], 32'h12);
        cyc(1);
        chk("s1_idle_data", req_data[31:0], 0);
        set_reply(0, 2'd1, 32'h146, 0);
        fire();
        chk("s1_no_err", err_valid, 0);
        ntag[0] = 1;
        wait_done(20);
        chk("s1_busy_low", busy, 0);
        chk("s1_pass", pass_cnt, 1);
        chk("s1_fail", fail_cnt, 0);
        cyc(1);
        chk("s1_done_pulse", done, 0);

        for (int p = 0; p < 4; p++) load(p, 4'd1, 32'h56, 32'h103);
        go();
        wait_issue(0, 10);
        for (int p = 0; p < 4; p++) begin
            chk("s2_i1_cmd", req_cmd[p*4 +: 4], 1);
            chk("s2_i1_data", req_data[p*32 +: 32], 32'h56);
            chk("s2_i1_tag", req_tag[p*2 +: 2], 64'(ntag[p]));
        end
        cyc(1);
        for (int p = 0; p < 4; p++) chk("s2_i2_data", req_data[p*32 +: 32], 32'h103);
        cyc(1);
        for (int p = 0; p < 4; p++) set_reply(p, 2'd1, 32'h159, ntag[p]);
        fire();
        for (int p = 0; p < 4; p++) ntag[p]++;
        wait_done(20);
        chk("s2_pass", pass_cnt, 4);
        chk("s2_fail", fail_cnt, 0);

        load(2, 4'd2, 32'h18, 32'h32);
        go();
        wait_issue(2, 10);
        chk("s3a_tag", req_tag[5:4], 64'(ntag[2]));
        cyc(2);
        set_reply(2, 2'd2, 32'hDEAD, ntag[2]);
        fire();
        chk("s3a_no_err", err_valid, 0);
        ntag[2]++;
        wait_done(20);
        chk("s3a_pass", pass_cnt, 1);
        chk("s3a_fail", fail_cnt, 0);

        load(2, 4'd2, 32'h18, 32'h32);
        go();
        wait_issue(2, 10);
        cyc(2);
        set_reply(2, 2'd1, 32'hDEAD, ntag[2]);
        fire();
        chk("s3b_err_valid", err_valid, 1);
        chk("s3b_err_port", err_port, 2);
        chk("s3b_err_tag", err_tag, 64'(ntag[2]));
        ntag[2]++;
        wait_done(20);
        chk("s3b_fail", fail_cnt, 1);
        chk("s3b_pass", pass_cnt, 0);

        for (int k = 0; k < 5; k++) load(1, 4'd1, 32'(k), 32'h1);
        go();
        chk("s4_ld_ready_busy", ld_ready, 0);
        load(1, 4'd1, 32'h77, 32'h1);
        for (int k = 0; k < 4; k++) begin
            wait_issue(1, 10);
            chk("s4_tag", req_tag[3:2], 64'((ntag[1] + k) % 4));
            cyc(1);
        end
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (req_cmd[7:4] != 4'd0) cnt++;
            cyc(1);
        end
        chk("s4_stall", 64'(cnt), 0);
        wait_issue(1, 300);
        chk("s4_5th_tag", req_tag[3:2], 64'(ntag[1]));
        chk("s4_5th_data", req_data[63:32], 32'h4);
        cyc(12);
        chk("s4_timeouts4", timeout_cnt, 4);
        wait_done(400);
        chk("s4_timeouts5", timeout_cnt, 5);
        chk("s4_pass_fail", {pass_cnt, fail_cnt}, 0);
        chk("s4_err_port", err_port, 1);
        chk("s4_err_tag", err_tag, 64'(ntag[1]));
        ntag[1] = (ntag[1] + 5) % 4;

        set_reply(3, 2'd1, 32'h0, 3);
        fire();
        chk("s5_err_valid", err_valid, 1);
        chk("s5_err_port", err_port, 3);
        chk("s5_err_tag", err_tag, 3);
        chk("s5_fail", fail_cnt, 1);
        cyc(1);
        chk("s5_err_pulse", err_valid, 0);

        load(0, 4'd1, 32'h5, 32'h6);
        go();
        wait_issue(0, 10);
        cyc(1);
        chk("s6_in_issue2", req_data[31:0], 32'h6);
        reset = 1'b1;
        #1;
        chk("s6_req_zero", 64'(req_cmd == 0 && req_data == 0 && req_tag == 0), 1);
        chk("s6_busy", busy, 0);
        chk("s6_cnts", {pass_cnt, fail_cnt, timeout_cnt}, 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) reset = 1'b0;
            cyc(1);
            if (done !== 1'b0) cnt++;
        end
        chk("s6_no_done", 64'(cnt), 0);
        load(0, 4'd5, 32'h1, 32'd31);
        go();
        wait_issue(0, 10);
        chk("s6_cmd", req_cmd[3:0], 5);
        chk("s6_tag", req_tag[1:0], 0);
        cyc(2);
        set_reply(0, 2'd1, 32'h80000000, 0);
        fire();
        wait_done(20);
        chk("s6_pass", pass_cnt, 1);
        chk("s6_fail", fail_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calc_traffic_engine.md
Name: calc_traffic_engine

Overview:
- Parametrised, synthesizable, self-checking traffic engine for the calc2 family of calculator DUTs.
- Each of NUM_PORTS channels has its own request FIFO, issues commands using the two-cycle calc2 request protocol, and allocates tags so several requests are outstanding per port.
- Responses are matched by tag, compared against a built-in reference model, and counted.
- It replaces per-test sequential driving: requests may be out of order, on any port count, with timeouts.

Parameters:
- NUM_PORTS, 4, number of request/response channels.
- DATA_W, 32, operand/result width.
- TAG_W, 2, tag width; 2**TAG_W tags outstanding per port max.
- FIFO_DEPTH, 8, request FIFO entries per port (power of two).
- TIMEOUT, 255, cycles an outstanding tag may wait before being retired as timed out.
- CNT_W, 16, width of statistics counters.

Ports:
- c_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  load request into FIFO of ld_port.
- ld_port  in  $clog2(NUM_PORTS)  target port.
- ld_cmd  in  4  command: 1 add, 2 sub, 5 shl, 6 shr.
- ld_op1  in  DATA_W  operand 1.
- ld_op2  in  DATA_W  operand 2.
- ld_ready  out  1  selected FIFO not full and engine not busy.
- start  in  1  pulse; begin issuing all loaded requests.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- req_cmd  out  NUM_PORTS*4  per-port command to DUT.
- req_data  out  NUM_PORTS*DATA_W  per-port data to DUT.
- req_tag  out  NUM_PORTS*TAG_W  per-port tag to DUT.
- out_resp  in  NUM_PORTS*2  DUT response: 0 none, 1 ok, 2 overflow/underflow/invalid.
- out_data  in  NUM_PORTS*DATA_W  DUT result.
- out_tag  in  NUM_PORTS*TAG_W  DUT response tag.
- pass_cnt  out  CNT_W  matched correct responses.
- fail_cnt  out  CNT_W  mismatches plus unexpected tags.
- timeout_cnt  out  CNT_W  retired timed-out tags.
- err_valid  out  1  one-cycle pulse on any failure or timeout.
- err_port  out  $clog2(NUM_PORTS)  port of reported error.
- err_tag  out  TAG_W  tag of reported error.

Behaviour:
- Reset (async): all FIFOs empty; all tag tables invalid; tag counters 0; FSMs IDLE; req_* = 0; busy, done, err_valid = 0; counters = 0; err_port, err_tag = 0.
- Reset mid-run abandons all traffic; no done pulse.
- Load: write on ld_valid && ld_ready. ld_valid while !ld_ready is ignored, with no state change.
- start while busy or with all FIFOs empty: ignored. Otherwise busy=1 next cycle and counters clear.
- Per-port FSM:
  - IDLE: if busy, FIFO non-empty and table[next_tag] invalid → ISSUE1.
  - ISSUE1: drive cmd, op1 and next_tag for exactly one cycle; mark entry valid with expected resp/data and age=0 → ISSUE2.
  - ISSUE2: drive cmd=0, data=op2, tag=0; pop FIFO; next_tag++ (wraps) → IDLE.
  - In IDLE, req_cmd/data/tag = 0.
  - Back-to-back requests take 3 cycles each (ISSUE1, ISSUE2, IDLE).
- Reference model, computed at ISSUE1; results are modulo 2**DATA_W:
  - add: resp 2 on carry-out, else resp 1, sum.
  - sub: resp 2 if op2>op1, else resp 1, op1-op2.
  - shl/shr: shift by op2[$clog2(DATA_W)-1:0], resp 1.
  - any other cmd: resp 2.
  - When expected resp is 2, data is not compared.
- Response check, any cycle out_resp[p]!=0:
  - Entry invalid → fail_cnt++ (unexpected tag).
  - Else resp equal and (resp==2 or data equal) → pass_cnt++; else fail_cnt++.
  - Matched entry invalidated the same cycle.
  - A response for a tag being allocated the same cycle cannot occur, because issue requires the entry to be invalid.
- Timeout: each valid entry's age increments per cycle. On age==TIMEOUT the entry is invalidated and timeout_cnt++. A response arriving the same cycle wins; no timeout is counted.
- Multiple failures in one cycle: counters add the count of failing ports. err_port/err_tag report the lowest-numbered failing port; failures take precedence over timeouts.
- Counters saturate at all-ones.
- done: when busy, all FIFOs empty, all FSMs IDLE and all tables invalid → done=1 for one cycle and busy=0 in the same cycle. Counters hold until next start.

Test Plan:
- Port0 load sub 32'h158, 32'h12; start; DUT replies resp 1, data 32'h146, tag 0 → pass_cnt=1, done pulses, busy low.
- All 4 ports load add 32'h56, 32'h103 → each port issues ISSUE1 cmd 1/data 32'h56 then data 32'h103; correct replies 32'h159 → pass_cnt=4.
- Port2 sub 32'h18, 32'h32; DUT replies resp 2 with data 32'hDEAD → pass (data ignored); DUT replies resp 1 instead → fail_cnt=1, err_port=2, err_tag=0.
- Port1 loads 5 requests with TAG_W=2 and DUT silent → tags 0..3 issued, 5th stalls; after TIMEOUT cycles timeout_cnt=4, then 5th issues with tag 0.
- DUT reply on port3 with tag 3 while nothing outstanding → fail_cnt=1, err_valid pulse, err_port=3, err_tag=3.
- Assert reset during ISSUE2 → req_* = 0 immediately, busy=0, counters 0, no done pulse; shl 1,31 after restart → expected 32'h80000000 resp 1.
